// File: rtl/mem_access_stage.sv
// mem_access_stage
// -----------------------------------------------------------------------------
// Memory-access stage of the 64-bit LEGv8 pipeline. It takes one EX/MEM entry
// per acceptance and does the following:
//   - resolves the branch and sends pc_src / branch_target back to fetch,
//   - performs a load or store through a req/ready handshake with data memory,
//   - drives the MEM/WB entry (wb_*).
// While a memory access is outstanding the stage holds the upstream pipe with
// mem_stall. An access is aborted with an err pulse after TIMEOUT cycles
// without dmem_ready.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   ex_valid                   EX/MEM holds a valid instruction (sampled in IDLE)
//   ex_instr                   instruction word; rd = ex_instr[4:0]
//   ex_result                  ALU result, also the memory address
//   ex_data2                   store data
//   ex_branch_addr             computed branch target
//   ex_zero/b/bz/bnz           ALU zero flag and branch kind
//   ex_mem_read/mem_write      memory op control bits
//   ex_mem_to_reg/reg_write    write-back control bits
//   mem_stall                  high while an access is outstanding
//   pc_src, branch_target      branch taken pulse and its target
//   dmem_req/we/addr/wdata     data memory request
//   dmem_ready, dmem_rdata     data memory completion and load data
//   wb_valid/reg_write/rd/data MEM/WB entry (wb_valid is a one-cycle pulse)
//   err                        pulse: misaligned, read+write, or timeout
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_instr,
   input  logic [63:0] ex_result,
   input  logic [63:0] ex_data2,
   input  logic [63:0] ex_branch_addr,
   input  logic        ex_zero,
   input  logic        ex_b,
   input  logic        ex_bz,
   input  logic        ex_bnz,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_to_reg,
   input  logic        ex_reg_write,
   output logic        mem_stall,
   output logic        pc_src,
   output logic [63:0] branch_target,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [63:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [63:0] wb_data,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   // Fields of the accepted entry still needed when the access completes.
   typedef struct packed {
      logic [4:0]  rd;
      logic        mem_read;
      logic        mem_to_reg;
      logic        reg_write;
      logic [63:0] result;
   } cap_t;

   state_t        state;
   cap_t          cap;
   logic [CW-1:0] cnt;

   logic [4:0] ex_rd;
   logic       take_branch;
   logic       mem_op;
   logic       mem_legal;
   logic       cap_xzr;

   assign ex_rd       = ex_instr[4:0];
   assign take_branch = ex_b | (ex_bz & ex_zero) | (ex_bnz & ~ex_zero);
   assign mem_op      = ex_mem_read | ex_mem_write;
   // Exactly one direction and a doubleword-aligned address.
   assign mem_legal   = (ex_mem_read ^ ex_mem_write) && (ex_result[2:0] == 3'b000);
   assign cap_xzr     = (cap.rd == 5'd31);

   // Only rd is decoded here; the rest of the word is carried for the pipe.
   logic unused_instr;
   assign unused_instr = ^ex_instr[31:5];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cap           <= '0;
         cnt           <= '0;
         mem_stall     <= 1'b0;
         pc_src        <= 1'b0;
         branch_target <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         err           <= 1'b0;
      end else begin
         // Pulsed outputs default low every cycle.
         pc_src       <= 1'b0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         err          <= 1'b0;

         case (state)
            IDLE: begin
               if (ex_valid) begin
                  // Branches resolve at acceptance, independent of any memory op.
                  pc_src        <= take_branch;
                  branch_target <= ex_branch_addr;

                  if (!mem_op) begin
                     wb_valid     <= 1'b1;
                     wb_rd        <= ex_rd;
                     wb_data      <= ex_result;
                     wb_reg_write <= ex_reg_write & (ex_rd != 5'd31);
                  end else if (!mem_legal) begin
                     // Illegal op: retire it without a request and without a write.
                     err      <= 1'b1;
                     wb_valid <= 1'b1;
                     wb_rd    <= ex_rd;
                     wb_data  <= ex_result;
                  end else begin
                     state          <= ACCESS;
                     mem_stall      <= 1'b1;
                     dmem_req       <= 1'b1;
                     dmem_we        <= ex_mem_write;
                     dmem_addr      <= ex_result;
                     dmem_wdata     <= ex_data2;
                     cnt            <= '0;
                     cap.rd         <= ex_rd;
                     cap.mem_read   <= ex_mem_read;
                     cap.mem_to_reg <= ex_mem_to_reg;
                     cap.reg_write  <= ex_reg_write;
                     cap.result     <= ex_result;
                  end
               end
            end

            ACCESS: begin
               if (dmem_ready) begin
                  state     <= IDLE;
                  mem_stall <= 1'b0;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  wb_valid  <= 1'b1;
                  wb_rd     <= cap.rd;
                  wb_data   <= (cap.mem_read && cap.mem_to_reg) ? dmem_rdata : cap.result;
                  // Stores never write the register file.
                  wb_reg_write <= cap.mem_read & cap.reg_write & ~cap_xzr;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  // This cycle is the TIMEOUT-th without ready: abort.
                  state     <= IDLE;
                  mem_stall <= 1'b0;
                  dmem_req  <= 1'b0;
                  dmem_we   <= 1'b0;
                  err       <= 1'b1;
                  wb_valid  <= 1'b1;
                  wb_rd     <= cap.rd;
                  wb_data   <= cap.result;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps

module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid;
   logic [31:0] ex_instr;
   logic [63:0] ex_result, ex_data2, ex_branch_addr;
   logic        ex_zero, ex_b, ex_bz, ex_bnz;
   logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
   logic        mem_stall, pc_src;
   logic [63:0] branch_target;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic        dmem_ready;
   logic [63:0] dmem_rdata;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        err;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_result(ex_result),
      .ex_data2(ex_data2), .ex_branch_addr(ex_branch_addr),
      .ex_zero(ex_zero), .ex_b(ex_b), .ex_bz(ex_bz), .ex_bnz(ex_bnz),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .err(err)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ex;
      ex_valid = 0; ex_instr = '0; ex_result = '0; ex_data2 = '0; ex_branch_addr = '0;
      ex_zero = 0; ex_b = 0; ex_bz = 0; ex_bnz = 0;
      ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_reg_write = 0;
   endtask

   task automatic set_ex(input logic [4:0] rd, input logic [63:0] res, input logic [63:0] d2,
                         input logic rdb, input logic wrb, input logic m2r, input logic rw);
      clr_ex();
      ex_valid = 1; ex_instr = {27'h0, rd}; ex_result = res; ex_data2 = d2;
      ex_mem_read = rdb; ex_mem_write = wrb; ex_mem_to_reg = m2r; ex_reg_write = rw;
   endtask

   task automatic test_reset;
      #3;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall got %b want 0", mem_stall); end
      checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem got req=%b we=%b want 0", dmem_req, dmem_we); end
      checks++; if ({wb_valid, wb_reg_write, err, pc_src} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b want 0000", {wb_valid, wb_reg_write, err, pc_src}); end
      checks++; if (branch_target !== 64'h0 || wb_data !== 64'h0 || dmem_addr !== 64'h0 || wb_rd !== 5'h0) begin
         errors++; $display("FAIL reset_data got bt=%h wd=%h addr=%h rd=%0d want 0", branch_target, wb_data, dmem_addr, wb_rd); end
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_alu;
      set_ex(5'd3, 64'h10, 64'h0, 0, 0, 0, 1);
      tick(); clr_ex();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %b want 1", wb_valid); end
      checks++; if (wb_rd !== 5'd3 || wb_data !== 64'h10) begin errors++; $display("FAIL alu_wb got rd=%0d data=%h want rd=3 data=10", wb_rd, wb_data); end
      checks++; if (wb_reg_write !== 1'b1 || mem_stall !== 1'b0) begin errors++; $display("FAIL alu_ctrl got rw=%b stall=%b want 1/0", wb_reg_write, mem_stall); end
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b want 0", wb_valid); end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 3; i++) begin
         set_ex(5'(i + 8), 64'(i * 256), 64'h0, 0, 0, 0, 1);
         tick();
         checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'(i + 8) || wb_data !== 64'(i * 256)) begin
            errors++; $display("FAIL b2b_%0d got v=%b rd=%0d data=%h want 1/%0d/%h", i, wb_valid, wb_rd, wb_data, i + 8, i * 256); end
      end
      clr_ex(); tick();
   endtask

   task automatic test_load;
      set_ex(5'd5, 64'h40, 64'h0, 1, 0, 1, 1);
      tick(); clr_ex();   // acceptance edge
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h40) begin
         errors++; $display("FAIL ld_req got req=%b we=%b addr=%h want 1/0/40", dmem_req, dmem_we, dmem_addr); end
      // Three wait cycles: request and address must hold, stage stalled.
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h40 || mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL ld_wait_%0d got req=%b addr=%h stall=%b wbv=%b want 1/40/1/0", i, dmem_req, dmem_addr, mem_stall, wb_valid); end
      end
      dmem_ready = 1; dmem_rdata = 64'hDEAD;
      tick(); dmem_ready = 0; dmem_rdata = '0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hDEAD || wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin
         errors++; $display("FAIL ld_wb got v=%b data=%h rd=%0d rw=%b want 1/dead/5/1", wb_valid, wb_data, wb_rd, wb_reg_write); end
      checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL ld_done got req=%b stall=%b want 0/0", dmem_req, mem_stall); end
   endtask

   task automatic test_store;
      set_ex(5'd7, 64'h48, 64'h1234, 0, 1, 0, 0);
      tick(); clr_ex();
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h48 || dmem_wdata !== 64'h1234) begin
         errors++; $display("FAIL st_req got req=%b we=%b addr=%h wdata=%h want 1/1/48/1234", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
      dmem_ready = 1;
      tick(); dmem_ready = 0;
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL st_wb got v=%b rw=%b req=%b want 1/0/0", wb_valid, wb_reg_write, dmem_req); end
   endtask

   task automatic test_branch;
      clr_ex(); ex_valid = 1; ex_bz = 1; ex_zero = 1; ex_branch_addr = 64'h200; ex_instr = 32'd31;
      tick(); clr_ex();
      checks++; if (pc_src !== 1'b1 || branch_target !== 64'h200) begin errors++; $display("FAIL cbz got pc_src=%b tgt=%h want 1/200", pc_src, branch_target); end
      tick();
      checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL cbz_pulse got %b want 0", pc_src); end
      ex_valid = 1; ex_bnz = 1; ex_zero = 1; ex_branch_addr = 64'h300; ex_instr = 32'd31;
      tick(); clr_ex();
      checks++; if (pc_src !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL cbnz got pc_src=%b wbv=%b want 0/1", pc_src, wb_valid); end
      // Branch resolved at acceptance of a load, before its completion.
      set_ex(5'd4, 64'h50, 64'h0, 1, 0, 1, 1); ex_b = 1; ex_branch_addr = 64'h400;
      tick(); clr_ex();
      checks++; if (pc_src !== 1'b1 || branch_target !== 64'h400 || dmem_req !== 1'b1) begin
         errors++; $display("FAIL b_ld got pc_src=%b tgt=%h req=%b want 1/400/1", pc_src, branch_target, dmem_req); end
      dmem_ready = 1; dmem_rdata = 64'h77;
      tick(); dmem_ready = 0;
      checks++; if (pc_src !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 64'h77) begin
         errors++; $display("FAIL b_ld_done got pc_src=%b wbv=%b data=%h want 0/1/77", pc_src, wb_valid, wb_data); end
   endtask

   task automatic test_illegal;
      set_ex(5'd6, 64'h44, 64'h0, 1, 0, 1, 1);
      tick(); clr_ex();
      checks++; if (err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL misalign got err=%b wbv=%b rw=%b req=%b stall=%b want 1/1/0/0/0", err, wb_valid, wb_reg_write, dmem_req, mem_stall); end
      set_ex(5'd6, 64'h40, 64'h5, 1, 1, 1, 1);
      tick(); clr_ex();
      checks++; if (err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL rdwr got err=%b wbv=%b rw=%b req=%b want 1/1/0/0", err, wb_valid, wb_reg_write, dmem_req); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", err); end
   endtask

   task automatic test_timeout;
      int n;
      int early_err;
      set_ex(5'd2, 64'h60, 64'h0, 1, 0, 1, 1);
      tick(); clr_ex();
      n = 0; early_err = 0;
      while (dmem_req === 1'b1 && n < 40) begin
         tick(); n++;
         if (dmem_req === 1'b1 && err !== 1'b0) early_err++;
      end
      checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles got %0d want 16", n); end
      checks++; if (early_err !== 0) begin errors++; $display("FAIL timeout_early_err got %0d want 0", early_err); end
      checks++; if (err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL timeout_abort got err=%b wbv=%b rw=%b stall=%b want 1/1/0/0", err, wb_valid, wb_reg_write, mem_stall); end
   endtask

   task automatic test_ready_ignored;
      dmem_ready = 1; dmem_rdata = 64'hBAD;
      tick(); dmem_ready = 0;
      checks++; if (wb_valid !== 1'b0 || err !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL stray_ready got wbv=%b err=%b stall=%b want 0/0/0", wb_valid, err, mem_stall); end
   endtask

   task automatic test_xzr;
      set_ex(5'd31, 64'h70, 64'h0, 1, 0, 1, 1);
      tick(); clr_ex();
      dmem_ready = 1; dmem_rdata = 64'h99;
      tick(); dmem_ready = 0;
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd31 || wb_reg_write !== 1'b0) begin
         errors++; $display("FAIL xzr_ld got v=%b rd=%0d rw=%b want 1/31/0", wb_valid, wb_rd, wb_reg_write); end
      set_ex(5'd31, 64'h5, 64'h0, 0, 0, 0, 1);
      tick(); clr_ex();
      checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
         errors++; $display("FAIL xzr_alu got v=%b rw=%b want 1/0", wb_valid, wb_reg_write); end
   endtask

   task automatic test_reset_access;
      set_ex(5'd8, 64'h80, 64'h0, 1, 0, 1, 1);
      tick(); clr_ex();
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_req got %b want 1", dmem_req); end
      #2 rst_n = 0;
      #1;
      checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL rst_acc_async got req=%b stall=%b want 0/0", dmem_req, mem_stall); end
      dmem_ready = 1;
      tick();
      rst_n = 1; dmem_ready = 0;
      tick();
      checks++; if (wb_valid !== 1'b0 || err !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL rst_acc_after got wbv=%b err=%b req=%b want 0/0/0", wb_valid, err, dmem_req); end
   endtask

   initial begin
      clr_ex();
      dmem_ready = 0; dmem_rdata = '0;
      test_reset();
      test_alu();
      test_back_to_back();
      test_load();
      test_store();
      test_branch();
      test_illegal();
      test_timeout();
      test_ready_ignored();
      test_xzr();
      test_reset_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
